// File: rtl/alu_regfile_datapath.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile_datapath
// Brief    : 16x32 register file (2 async read, 1 sync write) + combinational
//            ALU with C/Z/N/V flags. Optional macro: REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_regfile_datapath #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] data_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH-1:0] addr_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] alu_a,
    input  logic [DATA_WIDTH-1:0] alu_b,
    input  logic [3:0]            alu_op,
    input  logic [7:0]            flags_in,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic [7:0]            flags_out
);

    localparam logic [3:0] c_OP_ADD   = 4'h0;
    localparam logic [3:0] c_OP_SUB   = 4'h1;
    localparam logic [3:0] c_OP_ADC   = 4'h2;
    localparam logic [3:0] c_OP_SBC   = 4'h3;
    localparam logic [3:0] c_OP_AND   = 4'h4;
    localparam logic [3:0] c_OP_OR    = 4'h5;
    localparam logic [3:0] c_OP_XOR   = 4'h6;
    localparam logic [3:0] c_OP_NOT   = 4'h7;
    localparam logic [3:0] c_OP_SHL   = 4'h8;
    localparam logic [3:0] c_OP_SHR   = 4'h9;
    localparam logic [3:0] c_OP_SAR   = 4'hA;
    localparam logic [3:0] c_OP_PASSB = 4'hB;
    localparam logic [3:0] c_OP_CMP   = 4'hC;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
        end else if (write_en) begin
            regs_d[addr_w] = data_w;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write so the FSM sees it without a stall cycle.
    assign data_a = (write_en && rst_n && (addr_a == addr_w)) ? data_w : regs_q[addr_a];
    assign data_b = (write_en && rst_n && (addr_b == addr_w)) ? data_w : regs_q[addr_b];
`else
    assign data_a = regs_q[addr_a];
    assign data_b = regs_q[addr_b];
`endif

    logic                  w_cin;
    logic [4:0]            w_amt;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_shl_pre;
    logic [DATA_WIDTH-1:0] w_shr_pre;
    logic [DATA_WIDTH-1:0] w_res;
    logic [DATA_WIDTH-1:0] w_zn_val;
    logic                  w_c;
    logic                  w_v;
    logic                  w_add_v;
    logic                  w_sub_v;

    assign w_cin     = flags_in[0];
    assign w_amt     = alu_b[4:0];
    assign w_shl_pre = alu_a << (w_amt - 5'd1);
    assign w_shr_pre = alu_a >> (w_amt - 5'd1);
    assign w_add_v   = (alu_a[DATA_WIDTH-1] == alu_b[DATA_WIDTH-1]) &&
                       (w_sum[DATA_WIDTH-1] != alu_a[DATA_WIDTH-1]);
    assign w_sub_v   = (alu_a[DATA_WIDTH-1] != alu_b[DATA_WIDTH-1]) &&
                       (w_diff[DATA_WIDTH-1] != alu_a[DATA_WIDTH-1]);

    always_comb begin
        w_sum    = {1'b0, alu_a} + {1'b0, alu_b} +
                   {{DATA_WIDTH{1'b0}}, (alu_op == c_OP_ADC) & w_cin};
        // Bit DATA_WIDTH of the extended difference is the borrow.
        w_diff   = {1'b0, alu_a} - {1'b0, alu_b} -
                   {{DATA_WIDTH{1'b0}}, (alu_op == c_OP_SBC) & w_cin};
        w_res    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (alu_op)
            c_OP_ADD, c_OP_ADC: begin
                w_res = w_sum[DATA_WIDTH-1:0];
                w_c   = w_sum[DATA_WIDTH];
                w_v   = w_add_v;
            end
            c_OP_SUB, c_OP_SBC: begin
                w_res = w_diff[DATA_WIDTH-1:0];
                w_c   = w_diff[DATA_WIDTH];
                w_v   = w_sub_v;
            end
            c_OP_CMP: begin
                w_res = alu_a;
                w_c   = w_diff[DATA_WIDTH];
                w_v   = w_sub_v;
            end
            c_OP_AND:   w_res = alu_a & alu_b;
            c_OP_OR:    w_res = alu_a | alu_b;
            c_OP_XOR:   w_res = alu_a ^ alu_b;
            c_OP_NOT:   w_res = ~alu_a;
            c_OP_PASSB: w_res = alu_b;
            c_OP_SHL: begin
                w_res = alu_a << w_amt;
                w_c   = (w_amt == 5'd0) ? w_cin : w_shl_pre[DATA_WIDTH-1];
            end
            c_OP_SHR: begin
                w_res = alu_a >> w_amt;
                w_c   = (w_amt == 5'd0) ? w_cin : w_shr_pre[0];
            end
            c_OP_SAR: begin
                w_res = $unsigned($signed(alu_a) >>> w_amt);
                w_c   = (w_amt == 5'd0) ? w_cin : w_shr_pre[0];
            end
            default: begin
                w_res = '0;
            end
        endcase
        // CMP reports Z/N on the difference while returning operand A.
        w_zn_val = (alu_op == c_OP_CMP) ? w_diff[DATA_WIDTH-1:0] : w_res;
    end

    assign alu_result = w_res;

    always_comb begin
        flags_out = flags_in;
        if (alu_op <= c_OP_CMP) begin
            flags_out[0] = w_c;
            flags_out[1] = (w_zn_val == '0);
            flags_out[2] = w_zn_val[DATA_WIDTH-1];
            flags_out[3] = w_v;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_regfile_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_regfile_datapath
// Brief    : Directed self-checking bench for alu_regfile_datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_regfile_datapath;

    logic        clk;
    logic        rst_n;
    logic [3:0]  addr_a, addr_b, addr_w;
    logic [31:0] data_a, data_b, data_w;
    logic        write_en;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic [7:0]  flags_in, flags_out;

    int checks   = 0;
    int failures = 0;

    alu_regfile_datapath dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_a    (addr_a),
        .data_a    (data_a),
        .addr_b    (addr_b),
        .data_b    (data_b),
        .addr_w    (addr_w),
        .data_w    (data_w),
        .write_en  (write_en),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .flags_in  (flags_in),
        .alu_result(alu_result),
        .flags_out (flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [7:0] fin,
                           input logic [31:0] exp_res, input logic [7:0] exp_flags);
        alu_op = op; alu_a = a; alu_b = b; flags_in = fin;
        #1;
        check({tag, "_res"}, alu_result, exp_res);
        check({tag, "_flg"}, {24'h0, flags_out}, {24'h0, exp_flags});
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_w = a; data_w = d; write_en = 1'b1;
        @(posedge clk); #1;
        write_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; write_en = 1'b0;
        addr_a = '0; addr_b = '0; addr_w = '0; data_w = '0;
        alu_a = '0; alu_b = '0; alu_op = '0; flags_in = '0;

        // Reset with a competing write that must be discarded.
        @(negedge clk);
        rst_n = 1'b0; write_en = 1'b1; addr_w = 4'd5; data_w = 32'hDEADBEEF;
        @(posedge clk); #1;
        rst_n = 1'b1; write_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr_a = 4'(i); addr_b = 4'(15 - i); #1;
            check($sformatf("rst_a%0d", i), data_a, 32'h0);
            check($sformatf("rst_b%0d", 15 - i), data_b, 32'h0);
        end

        do_write(4'd3, 32'h12345678);
        do_write(4'd15, 32'hFFFFFFFF);
        do_write(4'd0, 32'h0000_00A5);
        addr_a = 4'd3; addr_b = 4'd15; #1;
        check("rd_r3", data_a, 32'h12345678);
        check("rd_r15", data_b, 32'hFFFFFFFF);
        addr_a = 4'd0; #1;
        check("rd_r0", data_a, 32'h000000A5);

        // Read-during-write on both ports.
        @(negedge clk);
        addr_w = 4'd3; data_w = 32'hCAFEF00D; write_en = 1'b1;
        addr_a = 4'd3; addr_b = 4'd3; #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_a", data_a, 32'hCAFEF00D);
        check("rdw_b", data_b, 32'hCAFEF00D);
`else
        check("rdw_a", data_a, 32'h12345678);
        check("rdw_b", data_b, 32'h12345678);
`endif
        @(posedge clk); #1;
        write_en = 1'b0; #1;
        check("rdw_after", data_a, 32'hCAFEF00D);

        // ALU vectors: op, a, b, flags_in, result, flags_out.
        alu_vec("add_carry", 4'h0, 32'hFFFFFFFF, 32'h1, 8'h00, 32'h0, 8'h03);
        alu_vec("add_ovf",   4'h0, 32'h7FFFFFFF, 32'h1, 8'h00, 32'h80000000, 8'h0C);
        alu_vec("add_user",  4'h0, 32'h2, 32'h3, 8'h3F, 32'h5, 8'h30);
        alu_vec("adc",       4'h2, 32'h1, 32'h1, 8'h01, 32'h3, 8'h00);
        alu_vec("sub",       4'h1, 32'h5, 32'h7, 8'h00, 32'hFFFFFFFE, 8'h05);
        alu_vec("sbc",       4'h3, 32'h5, 32'h5, 8'h01, 32'hFFFFFFFF, 8'h05);
        alu_vec("cmp_lt",    4'hC, 32'h5, 32'h7, 8'h00, 32'h5, 8'h05);
        alu_vec("cmp_eq",    4'hC, 32'h9, 32'h9, 8'h00, 32'h9, 8'h02);
        alu_vec("and",       4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 8'h0F, 32'h00F000F0, 8'h00);
        alu_vec("or",        4'h5, 32'hF0F0F0F0, 32'h0FF00FF0, 8'h00, 32'hFFF0FFF0, 8'h04);
        alu_vec("xor",       4'h6, 32'hF0F0F0F0, 32'h0FF00FF0, 8'h00, 32'hFF00FF00, 8'h04);
        alu_vec("not",       4'h7, 32'h0, 32'h0, 8'h00, 32'hFFFFFFFF, 8'h04);
        alu_vec("passb",     4'hB, 32'h1234, 32'h0, 8'h01, 32'h0, 8'h02);
        alu_vec("shl0",      4'h8, 32'h5, 32'h0, 8'h01, 32'h5, 8'h01);
        alu_vec("shl1",      4'h8, 32'h80000001, 32'h1, 8'h00, 32'h2, 8'h01);
        alu_vec("shr1",      4'h9, 32'h3, 32'h1, 8'h00, 32'h1, 8'h01);
        alu_vec("sar1",      4'hA, 32'h80000001, 32'h1, 8'h00, 32'hC0000000, 8'h05);
        alu_vec("rsv_e",     4'hE, 32'h5, 32'h7, 8'hA5, 32'h0, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
